// File: rtl/mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_unit
// Description : Pipeline MEM stage with a req/ready data-memory handshake,
//               load formatting (size/sign/endian) and a registered MEM/WB bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_unit #(
    parameter int ADDR_W      = 32,
    parameter int CTRL_W      = 17,
    parameter int RD_W        = 5,
    parameter int BIG_ENDIAN  = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       store_data_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [RD_W-1:0]   wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_rf_enable,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int   CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic c_big = (BIG_ENDIAN != 0);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    tmo_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [RD_W-1:0]     rd_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [1:0]  w_size;
    logic        w_misalign;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [1:0]  w_lane_q;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_se;
    logic [31:0] w_load;
    logic        w_tmo_hit;

    // Request-side decode from the incoming bundle.
    always_comb begin
        w_size     = ctrl_in[6:5];
        w_misalign = 1'b0;
        case (w_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = addr_in[0];
            2'b10:   w_misalign = (addr_in[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
        w_lane  = c_big ? (2'd3 - addr_in[1:0]) : addr_in[1:0];
        w_be    = 4'hF;
        w_wdata = store_data_in;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                w_be    = (addr_in[1] ^ c_big) ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = store_data_in;
            end
        endcase
    end

    // Response-side formatting uses the latched address and size.
    always_comb begin
        w_lane_q = c_big ? (2'd3 - addr_q[1:0]) : addr_q[1:0];
        w_byte   = mem_rdata[{w_lane_q, 3'b000} +: 8];
        w_half   = (addr_q[1] ^ c_big) ? mem_rdata[31:16] : mem_rdata[15:0];
        w_se     = ctrl_q[3];
        case (ctrl_q[6:5])
            2'b00:   w_load = {{24{w_se & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{w_se & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
        w_tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            ctrl_q       <= '0;
            rd_q         <= '0;
            addr_q       <= '0;
            stall        <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            wb_ctrl      <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_rf_enable <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ctrl_q <= ctrl_in;
                        rd_q   <= rd_in;
                        addr_q <= addr_in;
                        if (!ctrl_in[0] || w_misalign) begin
                            wb_valid     <= 1'b1;
                            wb_ctrl      <= ctrl_in;
                            wb_rd        <= rd_in;
                            wb_data      <= 32'(addr_in);
                            wb_rf_enable <= ctrl_in[9] & ~ctrl_in[0];
                            misalign_err <= ctrl_in[0];
                        end else begin
                            state_q   <= S_ACCESS;
                            tmo_q     <= '0;
                            stall     <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= ctrl_in[4];
                            mem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
                            mem_wdata <= w_wdata;
                            mem_be    <= w_be;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ready on the final allowed cycle takes priority over timeout.
                    if (mem_ready || w_tmo_hit) begin
                        state_q      <= S_IDLE;
                        stall        <= 1'b0;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_be       <= 4'h0;
                        wb_valid     <= 1'b1;
                        wb_ctrl      <= ctrl_q;
                        wb_rd        <= rd_q;
                        wb_data      <= (mem_ready && !ctrl_q[4]) ? w_load : 32'(addr_q);
                        wb_rf_enable <= mem_ready & ctrl_q[9];
                        bus_err      <= ~mem_ready;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_unit
// Description : Scoreboard bench for mem_stage_unit with a randomized memory
//               responder and a byte-addressed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_unit;

    localparam int  TMO = 4;
    localparam bit  BIG = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [16:0] ctrl_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        wb_valid;
    logic [16:0] wb_ctrl;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_rf_enable, misalign_err, bus_err;

    mem_stage_unit #(
        .ADDR_W(32), .CTRL_W(17), .RD_W(5), .BIG_ENDIAN(1), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ctrl_in(ctrl_in),
        .addr_in(addr_in), .store_data_in(store_data_in), .rd_in(rd_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_rf_enable(wb_rf_enable),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [16:0] ctrl;
        logic        rfen, mis, berr;
        int          cyc;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        int          waits;
    } req_t;

    wb_t  exp_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte at memory offset o within a word, as the bus presents it.
    function automatic logic [7:0] byte_at(input logic [31:0] w, input int o);
        return BIG ? w[8*(3-o) +: 8] : w[8*o +: 8];
    endfunction

    function automatic int lane_of(input int o);
        return BIG ? 3 - o : o;
    endfunction

    function automatic logic [16:0] mk(input bit en, input bit se, input bit st,
                                       input logic [1:0] sz, input bit rf);
        logic [16:0] c;
        c = '0;
        c[0] = en; c[3] = se; c[4] = st; c[6:5] = sz; c[9] = rf; c[10] = en & ~st;
        return c;
    endfunction

    task automatic issue(input logic [16:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd,
                         input logic [31:0] rdata, input int waits, input bit track);
        wb_t  e;
        req_t r;
        int   off, nb, acc, guard;
        bit   aligned;
        logic [1:0]  sz;
        logic [31:0] v;
        sz  = ctrl[6:5];
        off = int'(addr[1:0]);
        nb  = 1 << sz;
        aligned = (sz != 2'b11) && ((off % nb) == 0);
        guard = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            in_valid      = 1'($urandom_range(0, 1));
            ctrl_in       = 17'($urandom);
            addr_in       = $urandom;
            store_data_in = $urandom;
            rd_in         = 5'($urandom);
            guard++;
            if (guard > 200) begin
                bad++;
                $display("FAIL stall_stuck: got stall=1 expected release within 200 cycles");
                $fatal(1, "stall never released");
            end
        end
        in_valid = 1'b1; ctrl_in = ctrl; addr_in = addr; store_data_in = sd; rd_in = rd;
        acc = cyc + 1;
        e.rd = rd; e.ctrl = ctrl; e.data = addr; e.rfen = ctrl[9];
        e.mis = 1'b0; e.berr = 1'b0; e.cyc = acc;
        if (ctrl[0] && !aligned) begin
            e.mis = 1'b1; e.rfen = 1'b0;
        end else if (ctrl[0]) begin
            r.we = ctrl[4];
            r.addr = {addr[31:2], 2'b00};
            r.be = 4'h0;
            for (int i = 0; i < nb; i++) r.be[lane_of(off + i)] = 1'b1;
            r.wdata = (sz == 2'b00) ? sd[7:0] * 32'h0101_0101 :
                      (sz == 2'b01) ? sd[15:0] * 32'h0001_0001 : sd;
            r.rdata = rdata;
            r.waits = waits;
            req_q.push_back(r);
            if (waits >= TMO) begin
                e.berr = 1'b1; e.rfen = 1'b0; e.cyc = acc + TMO;
            end else begin
                e.cyc = acc + waits + 1;
                if (!ctrl[4]) begin
                    if (sz == 2'b00) begin
                        v = {24'h0, byte_at(rdata, off)};
                        if (ctrl[3] && v[7]) v = v - 32'h100;
                    end else if (sz == 2'b01) begin
                        v = BIG ? {16'h0, byte_at(rdata, off), byte_at(rdata, off + 1)}
                                : {16'h0, byte_at(rdata, off + 1), byte_at(rdata, off)};
                        if (ctrl[3] && v[15]) v = v - 32'h1_0000;
                    end else begin
                        v = BIG ? {byte_at(rdata, 0), byte_at(rdata, 1), byte_at(rdata, 2), byte_at(rdata, 3)}
                                : {byte_at(rdata, 3), byte_at(rdata, 2), byte_at(rdata, 1), byte_at(rdata, 0)};
                    end
                    e.data = v;
                end
            end
        end
        if (track) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Memory responder: checks each request once, then answers after its wait count.
    initial begin
        req_t cur;
        bit   active = 1'b0;
        int   cnt = 0;
        cur = '{we: 1'b0, addr: '0, wdata: '0, rdata: '0, be: '0, waits: 1000};
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (req_q.size() == 0) begin
                        chk("unexpected_mem_req", {31'h0, mem_req}, 32'h0);
                        cur.waits = 1000;
                    end else begin
                        cur = req_q.pop_front();
                        chk("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
                        chk("mem_addr", mem_addr, cur.addr);
                        chk("mem_be", {28'h0, mem_be}, {28'h0, cur.be});
                        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end
                if (cnt == cur.waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.rdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                cnt++;
            end else begin
                active = 1'b0;
                mem_ready = 1'b0;
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wb_valid", {31'h0, wb_valid}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_cycle", cyc, e.cyc);
                        chk("wb_data", wb_data, e.data);
                        chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                        chk("wb_ctrl", {15'h0, wb_ctrl}, {15'h0, e.ctrl});
                        chk("wb_rf_enable", {31'h0, wb_rf_enable}, {31'h0, e.rfen});
                        chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.mis});
                        chk("bus_err", {31'h0, bus_err}, {31'h0, e.berr});
                    end
                end else if (misalign_err || bus_err) begin
                    chk("stray_err_pulse", {30'h0, misalign_err, bus_err}, 32'h0);
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || stall) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        logic [16:0] c;
        reset = 1'b1; in_valid = 1'b0; ctrl_in = '0; addr_in = '0;
        store_data_in = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_bundle", {9'h0, wb_ctrl, wb_rd, wb_rf_enable}, 32'h0);
        chk("rst_errs", {30'h0, misalign_err, bus_err}, 32'h0);
        reset = 1'b0;

        issue(mk(0, 0, 0, 2'b00, 1), 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0, 1);
        issue(mk(1, 1, 0, 2'b00, 1), 32'h0000_0101, 32'h0, 5'd7, 32'h00F0_0000, 2, 1);
        issue(mk(1, 0, 0, 2'b00, 1), 32'h0000_0101, 32'h0, 5'd8, 32'h00F0_0000, 2, 1);
        issue(mk(1, 0, 1, 2'b01, 0), 32'h0000_0102, 32'h0000_ABCD, 5'd0, 32'h0, 1, 1);
        issue(mk(1, 0, 0, 2'b10, 1), 32'h0000_0102, 32'h0, 5'd9, 32'h0, 0, 1);
        issue(mk(1, 0, 0, 2'b10, 1), 32'h0000_0200, 32'h0, 5'd10, 32'h1234_5678, 20, 1);
        issue(mk(1, 1, 0, 2'b01, 1), 32'h0000_0302, 32'h0, 5'd11, 32'h1234_8765, TMO - 1, 1);
        issue(mk(1, 1, 0, 2'b10, 1), 32'h0000_0304, 32'h0, 5'd12, 32'h8000_0001, 0, 1);
        drain();

        for (int i = 0; i < 300; i++) begin
            c = 17'($urandom);
            c[0] = ($urandom_range(0, 3) != 0);
            issue(c, $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(0, TMO + 1), 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        issue(mk(1, 0, 0, 2'b10, 1), 32'h0000_0400, 32'h0, 5'd3, 32'hDEAD_BEEF, 50, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_access_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_in_access_stall", {31'h0, stall}, 32'h0);
        chk("rst_in_access_wb_valid", {31'h0, wb_valid}, 32'h0);
        reset = 1'b0;
        issue(mk(1, 1, 0, 2'b00, 1), 32'h0000_0503, 32'h0, 5'd4, 32'h0000_0080, 1, 1);
        drain();
        chk("req_queue_empty", req_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
